c_decode_binary_pipe: RTL and testbench



---
 rtl/c_decode_binary_pkg.sv | 36 +++
 rtl/c_decode_binary_pipe_stage.sv | 50 +++++
 rtl/c_decode_binary_pipe.sv | 103 ++++++++++
 tb/tb_c_decode_binary_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_decode_binary_pkg.sv
// c_decode_binary_pkg: shared limits and decode helpers for the pipelined
// binary-to-one-hot decoder. Helper functions work on the widest legal word;
// callers keep the low C_OUT_WIDTH bits.
package c_decode_binary_pkg;

  localparam int unsigned C_MIN_SEL_WIDTH   = 1;
  localparam int unsigned C_MAX_SEL_WIDTH   = 16;
  localparam int unsigned C_MIN_OUT_WIDTH   = 2;
  localparam int unsigned C_MAX_OUT_WIDTH   = 1 << C_MAX_SEL_WIDTH;
  localparam int unsigned C_MIN_PIPE_STAGES = 1;
  localparam int unsigned C_MAX_PIPE_STAGES = 8;

  typedef logic [C_MAX_OUT_WIDTH-1:0] word_max_t;
  typedef logic [C_MAX_SEL_WIDTH-1:0] sel_max_t;

  // All-inactive word: zeros for active-high, ones (in the used bits) otherwise.
  function automatic word_max_t inact_word(input int unsigned out_width,
                                           input bit          out_high);
    word_max_t mask;
    // Shifting by the full width wraps to zero, so the mask becomes all ones.
    mask = (word_max_t'(1) << out_width) - word_max_t'(1);
    return out_high ? '0 : mask;
  endfunction

  // One-hot / one-cold decode; disabled or out-of-range selects give INACT.
  function automatic word_max_t decode_word(input sel_max_t    sel,
                                            input logic        en,
                                            input int unsigned out_width,
                                            input bit          out_high);
    word_max_t word;
    word = inact_word(out_width, out_high);
    if (en && (32'(sel) < out_width)) word[sel] = out_high;
    return word;
  endfunction

endpackage

// File: rtl/c_decode_binary_pipe_stage.sv
// c_decode_binary_stage: one elastic valid/ready register slice with a
// generic payload. Ready looks through to the next slice so a full pipe can
// retire and accept on the same edge.
module c_decode_binary_stage #(
  parameter int unsigned             PAYLOAD_W = 8,
  parameter logic [PAYLOAD_W-1:0]    RST_DATA  = '0
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 ce,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [PAYLOAD_W-1:0] dn_data
);

  logic                 v_q, v_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;

  assign up_ready = ~v_q | dn_ready;
  assign dn_valid = v_q;
  assign dn_data  = data_q;

  // Next state: valid tracks upstream when this slice can move; data loads only on a real transfer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    v_d    = v_q;
    data_d = data_q;
    if (ce && up_ready) begin
      v_d = up_valid;
      if (up_valid) data_d = up_data;
    end
  end

  // Slice registers with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (sclr) begin
      v_q    <= 1'b0;
      // NOTE: data is reset too, so Q reads INACT (not stale X) before the first word.
      data_q <= RST_DATA;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/c_decode_binary_pipe.sv
// c_decode_binary_pipe: elastic pipelined binary-to-one-hot (or one-cold)
// decoder. Decode is combinational at the stage-0 input and the result is
// carried through C_PIPE_STAGES valid/ready slices.
// Optional feature macro: C_DECODE_BINARY_RANGE_ERR_EN adds the ERR output
// flagging an enabled, out-of-range select.
module c_decode_binary_pipe
  import c_decode_binary_pkg::*;
#(
  parameter int unsigned C_SEL_WIDTH   = 3,
  parameter int unsigned C_OUT_WIDTH   = 8,
  parameter int unsigned C_PIPE_STAGES = 1,
  parameter int unsigned C_OUT_HIGH    = 1
) (
  input  logic                   CLK,
  input  logic                   SCLR,
  input  logic                   CE,
  input  logic                   S_VALID,
  output logic                   S_READY,
  input  logic [C_SEL_WIDTH-1:0] S,
  input  logic                   EN,
  output logic                   Q_VALID,
  input  logic                   Q_READY,
  output logic [C_OUT_WIDTH-1:0] Q,
  output logic [C_SEL_WIDTH-1:0] Q_IDX
`ifdef C_DECODE_BINARY_RANGE_ERR_EN
  ,
  output logic                   ERR
`endif
);

  if (C_SEL_WIDTH < C_MIN_SEL_WIDTH || C_SEL_WIDTH > C_MAX_SEL_WIDTH ||
      C_OUT_WIDTH < C_MIN_OUT_WIDTH || C_OUT_WIDTH > (1 << C_SEL_WIDTH) ||
      C_PIPE_STAGES < C_MIN_PIPE_STAGES || C_PIPE_STAGES > C_MAX_PIPE_STAGES)
  begin : g_param_check
    $error("c_decode_binary_pipe: illegal parameter combination");
  end

`ifdef C_DECODE_BINARY_RANGE_ERR_EN
  localparam int unsigned ERR_W = 1;
`else
  localparam int unsigned ERR_W = 0;
`endif
  localparam int unsigned PW       = C_OUT_WIDTH + C_SEL_WIDTH + ERR_W;
  localparam bit          OUT_HIGH = (C_OUT_HIGH != 0);

  localparam word_max_t               INACT_FULL = inact_word(C_OUT_WIDTH, OUT_HIGH);
  localparam logic [C_OUT_WIDTH-1:0]  INACT      = INACT_FULL[C_OUT_WIDTH-1:0];
  // Payload layout, MSB first: [err] idx word.
  localparam logic [PW-1:0]           RST_WORD   = {{(PW-C_OUT_WIDTH){1'b0}}, INACT};

  word_max_t dec_full;
  logic      unused_dec_full;

  logic [C_PIPE_STAGES:0] pipe_valid;
  logic [C_PIPE_STAGES:0] pipe_ready;
  logic [PW-1:0]          pipe_data [0:C_PIPE_STAGES];

  // Stage-0 decode of the incoming select.
  always_comb begin
    dec_full = decode_word(sel_max_t'(S), EN, C_OUT_WIDTH, OUT_HIGH);
  end

  // Bits above C_OUT_WIDTH are constant and intentionally discarded.
  assign unused_dec_full = ^dec_full;

`ifdef C_DECODE_BINARY_RANGE_ERR_EN
  logic err0;
  assign err0         = EN & (32'(S) >= C_OUT_WIDTH);
  assign pipe_data[0] = {err0, S, dec_full[C_OUT_WIDTH-1:0]};
`else
  assign pipe_data[0] = {S, dec_full[C_OUT_WIDTH-1:0]};
`endif

  assign pipe_valid[0]             = S_VALID;
  assign pipe_ready[C_PIPE_STAGES] = Q_READY;
  // Nothing is accepted on the reset edge or while frozen.
  assign S_READY                   = CE & ~SCLR & pipe_ready[0];

  for (genvar i = 0; i < C_PIPE_STAGES; i++) begin : g_stage
    c_decode_binary_stage #(
      .PAYLOAD_W (PW),
      .RST_DATA  (RST_WORD)
    ) u_stage (
      .clk      (CLK),
      .sclr     (SCLR),
      .ce       (CE),
      .up_valid (pipe_valid[i]),
      .up_ready (pipe_ready[i]),
      .up_data  (pipe_data[i]),
      .dn_valid (pipe_valid[i+1]),
      .dn_ready (pipe_ready[i+1]),
      .dn_data  (pipe_data[i+1])
    );
  end

  assign Q_VALID = pipe_valid[C_PIPE_STAGES];
  assign Q       = pipe_data[C_PIPE_STAGES][C_OUT_WIDTH-1:0];
  assign Q_IDX   = pipe_data[C_PIPE_STAGES][C_OUT_WIDTH +: C_SEL_WIDTH];
`ifdef C_DECODE_BINARY_RANGE_ERR_EN
  assign ERR     = pipe_data[C_PIPE_STAGES][PW-1] & Q_VALID;
`endif

endmodule

// File: tb/tb_c_decode_binary_pipe.sv
// tb_c_decode_binary_pipe: two decoder instances.
//   dut_a: 3-bit select, 8-bit one-hot, 3 stages (streaming, backpressure,
//          CE freeze, mid-stream reset, random traffic).
//   dut_b: 3-bit select, 6-bit one-cold, 2 stages (EN / range behaviour).
// The reference is a FIFO of expected words plus an occupancy rule for ready.
`timescale 1ns/1ps
module tb_c_decode_binary_pipe;

  localparam int A_ST = 3;
  localparam int B_ST = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_sclr, a_ce, a_s_valid, a_s_ready, a_en, a_q_valid, a_q_ready;
  logic [2:0] a_s, a_q_idx;
  logic [7:0] a_q;
  logic       b_sclr, b_ce, b_s_valid, b_s_ready, b_en, b_q_valid, b_q_ready;
  logic [2:0] b_s, b_q_idx;
  logic [5:0] b_q;
`ifdef C_DECODE_BINARY_RANGE_ERR_EN
  logic       a_err, b_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_word_q [$];
  logic [2:0] exp_idx_q  [$];
  logic [7:0] last_word;
  logic [2:0] last_idx;

  c_decode_binary_pipe #(
    .C_SEL_WIDTH(3), .C_OUT_WIDTH(8), .C_PIPE_STAGES(A_ST), .C_OUT_HIGH(1)
  ) dut_a (
    .CLK(clk), .SCLR(a_sclr), .CE(a_ce), .S_VALID(a_s_valid), .S_READY(a_s_ready),
    .S(a_s), .EN(a_en), .Q_VALID(a_q_valid), .Q_READY(a_q_ready), .Q(a_q), .Q_IDX(a_q_idx)
`ifdef C_DECODE_BINARY_RANGE_ERR_EN
    , .ERR(a_err)
`endif
  );

  c_decode_binary_pipe #(
    .C_SEL_WIDTH(3), .C_OUT_WIDTH(6), .C_PIPE_STAGES(B_ST), .C_OUT_HIGH(0)
  ) dut_b (
    .CLK(clk), .SCLR(b_sclr), .CE(b_ce), .S_VALID(b_s_valid), .S_READY(b_s_ready),
    .S(b_s), .EN(b_en), .Q_VALID(b_q_valid), .Q_READY(b_q_ready), .Q(b_q), .Q_IDX(b_q_idx)
`ifdef C_DECODE_BINARY_RANGE_ERR_EN
    , .ERR(b_err)
`endif
  );

  // Reference decode for dut_a: bit S high when enabled, else all zeros.
  function automatic logic [7:0] a_ref_word(input logic [2:0] s, input logic en);
    return en ? (8'd1 << s) : 8'd0;
  endfunction

  // Reference decode for dut_b: all ones minus bit S when enabled and S<6.
  function automatic logic [5:0] b_ref_word(input logic [2:0] s, input logic en);
    return (en && s < 3'd6) ? (6'h3F - (6'd1 << s)) : 6'h3F;
  endfunction

  // One clock of dut_a: drive, check against the model, advance the model.
  task automatic step_a(input logic sv, input logic [2:0] s, input logic en,
                        input logic qr, input logic ce, input logic sclr,
                        output logic obs_qv);
    logic exp_rdy, out_x, in_x;
    @(negedge clk);
    a_s_valid = sv; a_s = s; a_en = en; a_q_ready = qr; a_ce = ce; a_sclr = sclr;
    #1;
    obs_qv  = a_q_valid;
    exp_rdy = ce && !sclr && (exp_word_q.size() < A_ST || qr);
    n_cmp++;
    if (a_s_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL a_s_ready: got %b want %b at %0t", a_s_ready, exp_rdy, $time);
    end
    n_cmp++;
    if (a_q_valid === 1'b1) begin
      if (exp_word_q.size() == 0) begin
        n_bad++;
        $display("FAIL a_q_valid: got 1 want 0 (no word outstanding) at %0t", $time);
      end else if (a_q !== exp_word_q[0] || a_q_idx !== exp_idx_q[0]) begin
        n_bad++;
        $display("FAIL a_q_data: got q=%h idx=%0d want q=%h idx=%0d at %0t",
                 a_q, a_q_idx, exp_word_q[0], exp_idx_q[0], $time);
      end
    end else if (a_q_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL a_q_valid: got %b want 0/1 at %0t", a_q_valid, $time);
    end else if (a_q !== last_word || a_q_idx !== last_idx) begin
      n_bad++;
      $display("FAIL a_q_hold: got q=%h idx=%0d want q=%h idx=%0d at %0t",
               a_q, a_q_idx, last_word, last_idx, $time);
    end
`ifdef C_DECODE_BINARY_RANGE_ERR_EN
    n_cmp++;
    if (a_err !== 1'b0) begin
      n_bad++;
      $display("FAIL a_err: got %b want 0 at %0t", a_err, $time);
    end
`endif
    out_x = ce && !sclr && (a_q_valid === 1'b1) && qr && (exp_word_q.size() > 0);
    in_x  = sv && exp_rdy;
    if (sclr) begin
      exp_word_q.delete();
      exp_idx_q.delete();
      last_word = 8'h00;
      last_idx  = 3'd0;
    end else begin
      if (out_x) begin
        last_word = exp_word_q.pop_front();
        last_idx  = exp_idx_q.pop_front();
      end
      if (in_x) begin
        exp_word_q.push_back(a_ref_word(s, en));
        exp_idx_q.push_back(s);
      end
    end
  endtask

  task automatic drain_a();
    logic qv;
    for (int k = 0; k < 40 && exp_word_q.size() > 0; k++)
      step_a(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, qv);
    n_cmp++;
    if (exp_word_q.size() != 0) begin
      n_bad++;
      $display("FAIL a_drain: got %0d words undelivered want 0", exp_word_q.size());
    end
  endtask

  task automatic test_reset();
    logic qv;
    for (int k = 0; k < 2; k++) begin
      step_a(1'b1, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, qv);
      n_cmp++;
      if (qv !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_q_valid: got %b want 0", qv);
      end
    end
    // First cycle out of reset: model expects S_READY=1 and Q=00 held.
    step_a(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, qv);
  endtask

  task automatic test_streaming();
    logic qv, want;
    for (int j = 0; j < 13; j++) begin
      step_a(j < 8, 3'(j), 1'b1, 1'b1, 1'b1, 1'b0, qv);
      want = (j >= A_ST) && (j < 8 + A_ST);
      n_cmp++;
      if (qv !== want) begin
        n_bad++;
        $display("FAIL stream_latency: step %0d got q_valid=%b want %b", j, qv, want);
      end
    end
  endtask

  task automatic test_backpressure();
    logic qv;
    for (int j = 0; j < 5; j++)
      step_a(1'b1, 3'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0, qv);
    for (int j = 0; j < 6; j++)
      step_a(1'b1, 3'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, qv);
    drain_a();
  endtask

  task automatic test_ce_freeze();
    logic qv, ref_qv;
    for (int j = 0; j < 5; j++)
      step_a(1'b1, 3'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, qv);
    step_a(1'b1, 3'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, ref_qv);
    n_cmp++;
    if (ref_qv !== 1'b1) begin
      n_bad++;
      $display("FAIL freeze_start_valid: got %b want 1", ref_qv);
    end
    for (int j = 0; j < 3; j++) begin
      step_a(1'b1, 3'($urandom), 1'b1, 1'(j % 2 == 0), 1'b0, 1'b0, qv);
      n_cmp++;
      if (qv !== ref_qv) begin
        n_bad++;
        $display("FAIL freeze_q_valid: got %b want %b", qv, ref_qv);
      end
    end
    for (int j = 0; j < 4; j++)
      step_a(1'b1, 3'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, qv);
    drain_a();
  endtask

  task automatic test_sclr_midstream();
    logic qv;
    step_a(1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, qv);
    step_a(1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, qv);
    step_a(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, qv);
    step_a(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, qv);
    n_cmp++;
    if (qv !== 1'b0) begin
      n_bad++;
      $display("FAIL sclr_mid_q_valid: got %b want 0", qv);
    end
    for (int j = 0; j < 3; j++)
      step_a(1'b1, 3'(j + 2), 1'b1, 1'b1, 1'b1, 1'b0, qv);
    drain_a();
  endtask

  task automatic test_random();
    logic qv;
    for (int j = 0; j < 400; j++)
      step_a(1'($urandom % 4 != 0), 3'($urandom), 1'($urandom % 8 != 0),
             1'($urandom % 3 != 0), 1'($urandom % 10 != 0), 1'b0, qv);
    drain_a();
  endtask

  // Send one word into dut_b and check latency, data, index and range flag.
  task automatic send_b(input logic [2:0] s, input logic en,
                        input logic [5:0] want_q, input logic want_err);
    int lat;
    @(negedge clk);
    b_s_valid = 1'b1; b_s = s; b_en = en; b_q_ready = 1'b1; b_ce = 1'b1; b_sclr = 1'b0;
    #1;
    n_cmp++;
    if (b_s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b_s_ready: got %b want 1", b_s_ready);
    end
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      b_s_valid = 1'b0;
      #1;
      if (b_q_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat != B_ST) begin
      n_bad++;
      $display("FAIL b_latency: got %0d want %0d (0 = timeout)", lat, B_ST);
    end
    n_cmp++;
    if (b_q !== want_q || b_q_idx !== s) begin
      n_bad++;
      $display("FAIL b_q_data: s=%0d en=%b got q=%b idx=%0d want q=%b idx=%0d",
               s, en, b_q, b_q_idx, want_q, s);
    end
`ifdef C_DECODE_BINARY_RANGE_ERR_EN
    n_cmp++;
    if (b_err !== want_err) begin
      n_bad++;
      $display("FAIL b_err: s=%0d en=%b got %b want %b", s, en, b_err, want_err);
    end
`else
    if (want_err === 1'bx) $display("note: want_err unknown");
`endif
  endtask

  task automatic test_en_range();
    logic [2:0] s;
    logic       en;
    send_b(3'd2, 1'b1, 6'b111011, 1'b0);
    send_b(3'd2, 1'b0, 6'b111111, 1'b0);
    send_b(3'd7, 1'b1, 6'b111111, 1'b1);
    send_b(3'd0, 1'b1, 6'b111110, 1'b0);
    send_b(3'd5, 1'b1, 6'b011111, 1'b0);
    for (int j = 0; j < 8; j++) begin
      s  = 3'($urandom);
      en = 1'($urandom);
      send_b(s, en, b_ref_word(s, en), en && (s >= 3'd6));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_sclr = 1'b1; a_ce = 1'b1; a_s_valid = 1'b0; a_s = 3'd0; a_en = 1'b0; a_q_ready = 1'b0;
    b_sclr = 1'b1; b_ce = 1'b1; b_s_valid = 1'b0; b_s = 3'd0; b_en = 1'b0; b_q_ready = 1'b1;
    last_word = 8'h00;
    last_idx  = 3'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_ce_freeze();
    test_sclr_midstream();
    test_random();
    test_en_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
